// File: rtl/game_sequencer.sv
// game_sequencer: frame-rate controller for the ball/paddle datapath.
// Sequences SERVE -> PLAY -> MISS -> (SERVE | OVER) and steps the ball once per
// frame_tick while in PLAY, resolving wall and paddle reflections.
// Optional build macro SPEEDUP_EN: every 4 paddle hits raise the vertical step
// by one (up to +2); cleared on a miss or reset. Without it the step is fixed.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SERVE 00 | ball parked at centre, waiting for launch or serve timeout
// PLAY  01 | ball moves one step per frame_tick
// MISS  10 | single cycle: lose a life, then re-serve or end the game
// OVER  11 | ball hidden, red field; launch restarts the game
module game_sequencer #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int EDGE         = 8,
   parameter int PADDLE_Y     = 460,
   parameter int PADDLE_HALF  = 32,
   parameter int BALL_DX      = 1,
   parameter int BALL_DY      = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int LIVES        = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       launch,
   input  logic [9:0] paddle_x,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [1:0] ball_dir,
   output logic       ball_visible,
   output logic [1:0] lives,
   output logic [1:0] state,
   output logic       game_over,
   output logic       hit_pulse
);

   typedef enum logic [1:0] {
      ST_SERVE = 2'b00,
      ST_PLAY  = 2'b01,
      ST_MISS  = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   localparam logic [10:0] X_MIN    = 11'(EDGE);
   localparam logic [10:0] X_MAX    = 11'(SCREEN_W - EDGE - 1);
   localparam logic [10:0] Y_MIN    = 11'(EDGE);
   localparam logic [10:0] Y_FLOOR  = 11'(SCREEN_H - EDGE);
   localparam logic [10:0] PAD_Y    = 11'(PADDLE_Y);
   localparam logic [10:0] PAD_HALF = 11'(PADDLE_HALF);
   localparam logic [10:0] DX       = 11'(BALL_DX);
   localparam logic [9:0]  CX       = 10'(SCREEN_W / 2);
   localparam logic [9:0]  CY       = 10'(SCREEN_H / 2);
   localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

   state_t           state_q, state_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic [1:0]       dir_q, dir_d;      // bit1 = up, bit0 = left
   logic [1:0]       lives_q, lives_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_q, hit_d;

   logic [10:0]        dy;
   logic [10:0]        x11, y11, p11;
   logic signed [10:0] diff, adiff;
   logic               paddle_ok;

`ifdef SPEEDUP_EN
   logic [2:0] hits_q, hits_d;
   logic [1:0] level_q, level_d;
   assign dy = 11'(BALL_DY) + {9'd0, level_q};
`else
   assign dy = 11'(BALL_DY);
`endif

   assign x11   = {1'b0, x_q};
   assign y11   = {1'b0, y_q};
   assign p11   = {1'b0, paddle_x};
   assign diff  = signed'(x11 - p11);
   assign adiff = diff[10] ? -diff : diff;
   assign paddle_ok = (unsigned'(adiff) < PAD_HALF);

   // Next-state, ball motion and life bookkeeping
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      lives_d = lives_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;
`ifdef SPEEDUP_EN
      hits_d  = hits_q;
      level_d = level_q;
`endif
      case (state_q)
         ST_SERVE: begin
            x_d   = CX;
            y_d   = CY;
            dir_d = 2'b00;
            if (launch) begin
               state_d = ST_PLAY;
               cnt_d   = '0;
            end else if (frame_tick) begin
               if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                  state_d = ST_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_PLAY: begin
            if (frame_tick) begin
               if (!dir_q[0]) begin
                  if (x11 + DX >= X_MAX) begin
                     x_d      = X_MAX[9:0];
                     dir_d[0] = 1'b1;
                  end else begin
                     x_d = 10'(x11 + DX);
                  end
               end else begin
                  if (x11 <= X_MIN + DX) begin
                     x_d      = X_MIN[9:0];
                     dir_d[0] = 1'b0;
                  end else begin
                     x_d = 10'(x11 - DX);
                  end
               end
               if (dir_q[1]) begin
                  if (y11 <= Y_MIN + dy) begin
                     y_d      = Y_MIN[9:0];
                     dir_d[1] = 1'b0;
                  end else begin
                     y_d = 10'(y11 - dy);
                  end
               end else if ((y11 < PAD_Y) && (y11 + dy >= PAD_Y) && paddle_ok) begin
                  y_d      = PAD_Y[9:0];
                  dir_d[1] = 1'b1;
                  hit_d    = 1'b1;
`ifdef SPEEDUP_EN
                  if (hits_q == 3'd3) begin
                     hits_d = 3'd0;
                     if (level_q != 2'd2) level_d = level_q + 2'd1;
                  end else begin
                     hits_d = hits_q + 3'd1;
                  end
`endif
               end else if (y11 + dy >= Y_FLOOR) begin
                  y_d     = Y_FLOOR[9:0];
                  state_d = ST_MISS;
               end else begin
                  y_d = 10'(y11 + dy);
               end
            end
         end
         ST_MISS: begin
            lives_d = lives_q - 2'd1;
`ifdef SPEEDUP_EN
            hits_d  = 3'd0;
            level_d = 2'd0;
`endif
            if (lives_q == 2'd1) begin
               state_d = ST_OVER;
            end else begin
               state_d = ST_SERVE;
               x_d     = CX;
               y_d     = CY;
               dir_d   = 2'b00;
            end
         end
         ST_OVER: begin
            if (launch) begin
               state_d = ST_SERVE;
               x_d     = CX;
               y_d     = CY;
               dir_d   = 2'b00;
               lives_d = LIVES_INIT;
               cnt_d   = '0;
`ifdef SPEEDUP_EN
               hits_d  = 3'd0;
               level_d = 2'd0;
`endif
            end
         end
         default: state_d = ST_SERVE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SERVE;
         x_q     <= CX;
         y_q     <= CY;
         dir_q   <= 2'b00;
         lives_q <= LIVES_INIT;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_q   <= dir_d;
         lives_q <= lives_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
      end
   end

`ifdef SPEEDUP_EN
   // Speed-level tracking, only present in the speed-up build
   always_ff @(posedge clk) begin
      if (reset) begin
         hits_q  <= 3'd0;
         level_q <= 2'd0;
      end else begin
         hits_q  <= hits_d;
         level_q <= level_d;
      end
   end
`endif

   assign ball_x       = x_q;
   assign ball_y       = y_q;
   assign ball_dir     = dir_q;
   assign lives        = lives_q;
   assign state        = state_q;
   assign ball_visible = (state_q != ST_OVER);
   assign game_over    = (state_q == ST_OVER);
   assign hit_pulse    = hit_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed serve checks followed by randomized
// frame/launch/paddle traffic compared every cycle against a behavioural model.
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       reset, frame_tick, launch;
   logic [9:0] paddle_x;
   logic [9:0] ball_x, ball_y;
   logic [1:0] ball_dir, lives, state;
   logic       ball_visible, game_over, hit_pulse;

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .launch       (launch),
      .paddle_x     (paddle_x),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .ball_dir     (ball_dir),
      .ball_visible (ball_visible),
      .lives        (lives),
      .state        (state),
      .game_over    (game_over),
      .hit_pulse    (hit_pulse)
   );

   // model: phases 0 serve, 1 play, 2 miss, 3 over
   int m_st, m_x, m_y, m_left, m_up, m_lives, m_cnt, m_hit, m_hits, m_lvl;
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_x = 320; m_y = 240; m_left = 0; m_up = 0;
      m_lives = 3; m_cnt = 0; m_hit = 0; m_hits = 0; m_lvl = 0;
   endtask

   task automatic model_step(input bit r, input bit t, input bit l, input int p);
      int dy, d;
      if (r) begin
         model_reset();
         return;
      end
      m_hit = 0;
`ifdef SPEEDUP_EN
      dy = 2 + m_lvl;
`else
      dy = 2;
`endif
      case (m_st)
         0: begin
            if (l) begin
               m_st = 1; m_cnt = 0;
            end else if (t) begin
               if (m_cnt == 59) begin m_st = 1; m_cnt = 0; end
               else m_cnt++;
            end
         end
         1: if (t) begin
            d = m_x - p;
            if (d < 0) d = -d;
            if (m_up == 1) begin
               if (m_y <= 8 + dy) begin m_y = 8; m_up = 0; end
               else m_y -= dy;
            end else if (m_y < 460 && m_y + dy >= 460 && d < 32) begin
               m_y = 460; m_up = 1; m_hit = 1;
               m_hits++;
               if (m_hits == 4) begin
                  m_hits = 0;
                  if (m_lvl < 2) m_lvl++;
               end
            end else begin
               m_y += dy;
               if (m_y >= 472) begin m_y = 472; m_st = 2; end
            end
            if (m_left == 0) begin
               if (m_x + 1 >= 631) begin m_x = 631; m_left = 1; end
               else m_x += 1;
            end else begin
               if (m_x <= 9) begin m_x = 8; m_left = 0; end
               else m_x -= 1;
            end
         end
         2: begin
            m_lives--; m_hits = 0; m_lvl = 0;
            if (m_lives == 0) m_st = 3;
            else begin
               m_st = 0; m_x = 320; m_y = 240; m_left = 0; m_up = 0;
            end
         end
         default: if (l) model_reset();
      endcase
   endtask

   task automatic compare_all();
      chk("ball_x", 32'(ball_x), 32'(m_x));
      chk("ball_y", 32'(ball_y), 32'(m_y));
      chk("ball_dir", 32'(ball_dir), 32'(m_up * 2 + m_left));
      chk("state", 32'(state), 32'(m_st));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("ball_visible", 32'(ball_visible), 32'(m_st != 3));
      chk("game_over", 32'(game_over), 32'(m_st == 3));
      chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
   endtask

   task automatic cycle(input bit r, input bit t, input bit l, input int p);
      @(negedge clk);
      reset = r; frame_tick = t; launch = l; paddle_x = 10'(p & 1023);
      @(posedge clk);
      model_step(r, t, l, p & 1023);
      #1;
      compare_all();
   endtask

   int offs[11] = '{0, 5, -5, 20, -20, 31, -31, 32, -32, 33, -33};
   int pad;
   bit rr, tt, ll;

   initial begin
      reset = 1'b1; frame_tick = 1'b0; launch = 1'b0; paddle_x = '0;
      model_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 1, 1, 0);
      chk("rst_x", 32'(ball_x), 320);
      chk("rst_y", 32'(ball_y), 240);
      chk("rst_state", 32'(state), 0);
      chk("rst_lives", 32'(lives), 3);

      // serve timeout: PLAY only after the 60th tick
      for (int i = 0; i < 60; i++) begin
         cycle(0, 1, 0, 0);
         if (i == 58) chk("serve_59", 32'(state), 0);
         cycle(0, 0, 0, 0);
      end
      chk("serve_60", 32'(state), 1);
      cycle(0, 1, 0, 0);
      chk("first_x", 32'(ball_x), 321);
      chk("first_y", 32'(ball_y), 242);

      // launch after three ticks
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      chk("launch_state", 32'(state), 1);
      chk("launch_x", 32'(ball_x), 320);
      chk("launch_y", 32'(ball_y), 240);

      // randomized traffic
      pad = 320;
      for (int i = 0; i < 60000; i++) begin
         rr = ($urandom_range(0, 4999) == 0);
         tt = ($urandom_range(0, 2) == 0);
         case (m_st)
            0:       ll = ($urandom_range(0, 149) == 0);
            3:       ll = ($urandom_range(0, 19) == 0);
            default: ll = ($urandom_range(0, 49) == 0);
         endcase
         if ($urandom_range(0, 9) < 7) begin
            if ($urandom_range(0, 3) == 0) pad = m_x + $urandom_range(0, 80) - 40;
            else pad = m_x + offs[$urandom_range(0, 10)];
         end else begin
            pad = $urandom_range(0, 1023);
         end
         cycle(rr, tt, ll, pad);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
